// File: rtl/smg_disp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : smg_disp_ctrl
//  Purpose  : Alarm-clock seven-segment controller. Selects time/alarm digits,
//             blinks the field under adjustment, and drives direct and scanned
//             active-low segment outputs.
//  Options  : define SMG_LZB_EN for leading-zero blanking of the top digit.
//  Revision : 1.0  initial release
// ============================================================================
module smg_disp_ctrl #(
    parameter int                 NUM_DIG    = 6,
    parameter int                 BLINK_CNT  = 10_000_000,
    parameter int                 SCAN_CNT   = 50_000,
    parameter logic [NUM_DIG-1:0] ALARM_MASK = NUM_DIG'(6'b111100)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             adjust,
    input  logic [4*NUM_DIG-1:0]   time_digits,
    input  logic [4*NUM_DIG-1:0]   alarm_digits,
    input  logic                   alarm_view,
    output logic [7*NUM_DIG-1:0]   hex_out,
    output logic [6:0]             seg_scan,
    output logic [NUM_DIG-1:0]     dig_sel
);

    localparam int         c_BW    = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
    localparam int         c_SW    = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int         c_IW    = (NUM_DIG > 2) ? $clog2(NUM_DIG) : 1;
    localparam logic [3:0] c_BLANK = 4'd10;

    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------------
    // Blink timing
    // ------------------------------------------------------------------------
    logic [3:0]      r_adjust;
    logic [c_BW-1:0] r_blink_cnt;
    logic [c_BW-1:0] w_blink_cnt_nxt;
    logic            r_blink_phase;
    logic            w_blink_phase_nxt;
    logic            w_restart;
    logic            w_blink_wrap;

    // A new adjust value restarts the half-period so the field is first shown
    // in full; restart takes precedence over a coincident wrap.
    always_comb begin
        w_restart         = (adjust != r_adjust);
        w_blink_wrap      = (r_blink_cnt == c_BW'(BLINK_CNT - 1));
        w_blink_cnt_nxt   = r_blink_cnt + c_BW'(1);
        w_blink_phase_nxt = r_blink_phase;
        if (w_restart) begin
            w_blink_cnt_nxt   = '0;
            w_blink_phase_nxt = 1'b0;
        end else if (w_blink_wrap) begin
            w_blink_cnt_nxt   = '0;
            w_blink_phase_nxt = ~r_blink_phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adjust      <= 4'd0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_adjust      <= adjust;
            r_blink_cnt   <= w_blink_cnt_nxt;
            r_blink_phase <= w_blink_phase_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Per-digit code selection
    // ------------------------------------------------------------------------
    logic [4*NUM_DIG-1:0] w_code_nxt;
    logic [4*NUM_DIG-1:0] r_code;

    // Selection uses the next blink phase so the registered code lines up with
    // the blink state it will be displayed alongside.
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        localparam logic [3:0] c_FIELD = 4'(i / 2);
        logic [3:0] w_src;
        logic [3:0] w_code;

        always_comb begin
            w_src = (alarm_view && ALARM_MASK[i]) ? alarm_digits[4*i +: 4]
                                                  : time_digits[4*i +: 4];
`ifdef SMG_LZB_EN
            if ((i == NUM_DIG - 1) && (w_src == 4'd0)) begin
                w_src = c_BLANK;
            end
`endif
            w_code = w_src;
            if ((adjust != 4'd0) && (adjust == c_FIELD) && w_blink_phase_nxt) begin
                w_code = c_BLANK;
            end
        end

        assign w_code_nxt[4*i +: 4] = w_code;
        assign hex_out[7*i +: 7]    = f_decode(r_code[4*i +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code <= {NUM_DIG{c_BLANK}};
        end else begin
            r_code <= w_code_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Scan multiplexer
    // ------------------------------------------------------------------------
    logic [c_SW-1:0]    r_scan_cnt;
    logic [c_IW-1:0]    r_scan_idx;
    logic [c_IW-1:0]    w_scan_idx_nxt;
    logic               w_scan_wrap;
    logic [3:0]         w_scan_code;
    logic [6:0]         r_seg_scan;
    logic [NUM_DIG-1:0] r_dig_sel;

    // seg_scan/dig_sel are built from next-state values so that, once
    // registered, they agree with hex_out of the digit being scanned.
    always_comb begin
        w_scan_wrap    = (r_scan_cnt == c_SW'(SCAN_CNT - 1));
        w_scan_idx_nxt = r_scan_idx;
        if (w_scan_wrap) begin
            w_scan_idx_nxt = (r_scan_idx == c_IW'(NUM_DIG - 1)) ? '0
                                                                : r_scan_idx + c_IW'(1);
        end
        w_scan_code = c_BLANK;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (w_scan_idx_nxt == c_IW'(k)) begin
                w_scan_code = w_code_nxt[4*k +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_seg_scan <= 7'h7F;
            r_dig_sel  <= NUM_DIG'(1);
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + c_SW'(1);
            r_scan_idx <= w_scan_idx_nxt;
            r_seg_scan <= f_decode(w_scan_code);
            r_dig_sel  <= NUM_DIG'(1) << w_scan_idx_nxt;
        end
    end

    assign seg_scan = r_seg_scan;
    assign dig_sel  = r_dig_sel;

endmodule
`default_nettype wire

// File: tb/tb_smg_disp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_smg_disp_ctrl
//  Purpose  : Randomised and directed bench for smg_disp_ctrl against an
//             age-based behavioural model (honours SMG_LZB_EN).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_smg_disp_ctrl;

    localparam int         NUM_DIG    = 6;
    localparam int         BLINK_CNT  = 4;
    localparam int         SCAN_CNT   = 2;
    localparam logic [5:0] ALARM_MASK = 6'b111100;
    localparam logic [6:0] c_GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
                                           7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  adjust = 4'd0;
    logic [23:0] time_digits = 24'h123456;
    logic [23:0] alarm_digits = 24'h000000;
    logic        alarm_view = 1'b0;
    logic [41:0] hex_out;
    logic [6:0]  seg_scan;
    logic [5:0]  dig_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: edges since last blink restart / since reset.
    logic [3:0]  m_adj_reg;
    int          m_age_b;
    int          m_age_s;
    logic [41:0] m_hex;
    logic [6:0]  m_seg;
    logic [5:0]  m_sel;

    smg_disp_ctrl #(
        .NUM_DIG   (NUM_DIG),
        .BLINK_CNT (BLINK_CNT),
        .SCAN_CNT  (SCAN_CNT),
        .ALARM_MASK(ALARM_MASK)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adjust      (adjust),
        .time_digits (time_digits),
        .alarm_digits(alarm_digits),
        .alarm_view  (alarm_view),
        .hex_out     (hex_out),
        .seg_scan    (seg_scan),
        .dig_sel     (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_adj_reg = 4'd0;
        m_age_b   = 0;
        m_age_s   = 0;
        m_hex     = {42{1'b1}};
        m_seg     = 7'h7F;
        m_sel     = 6'b000001;
    endtask

    task automatic model_edge();
        int   phase;
        int   idx;
        logic [3:0] code;
        if (!rst_n) return;
        if (adjust != m_adj_reg) m_age_b = 0;
        else                     m_age_b++;
        m_adj_reg = adjust;
        m_age_s++;
        phase = (m_age_b / BLINK_CNT) % 2;
        for (int i = 0; i < NUM_DIG; i++) begin
            code = (alarm_view && ALARM_MASK[i]) ? alarm_digits[4*i +: 4] : time_digits[4*i +: 4];
`ifdef SMG_LZB_EN
            if (i == NUM_DIG - 1 && code == 4'd0) code = 4'd10;
`endif
            if (adjust != 0 && int'(adjust) == i / 2 && phase == 1) code = 4'd10;
            m_hex[7*i +: 7] = c_GLYPH[code];
        end
        idx   = (m_age_s / SCAN_CNT) % NUM_DIG;
        m_sel = 6'(1 << idx);
        m_seg = m_hex[7*idx +: 7];
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_hex"}, 64'(hex_out), 64'(m_hex));
        check_eq({tag, "_seg"}, 64'(seg_scan), 64'(m_seg));
        check_eq({tag, "_sel"}, 64'(dig_sel), 64'(m_sel));
    endtask

    task automatic step(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_outputs(tag);
        end
    endtask

    function automatic logic [23:0] rand_digits();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) begin
            v[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 2) == 0) v[23:20] = 4'd0;
        return v;
    endfunction

    initial begin
        logic [3:0] adj_pool [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd15};

        // Reset held with outputs blank
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("rst");
        step(3, "rst_hold");

        // Release, first update on first edge
        #2 rst_n = 1'b1;
        step(1, "release");
        check_eq("rel_dig0", 64'(hex_out[6:0]), 64'(7'h02));
        check_eq("rel_dig5", 64'(hex_out[41:35]), 64'(7'h79));
        check_eq("rel_sel", 64'(dig_sel), 64'(6'b000001));

        // Field 1 blinks, then out-of-range field blinks nothing
        adjust = 4'd1;
        step(4, "adj1_vis");
        check_eq("adj1_dig2_vis", 64'(hex_out[20:14]), 64'(7'h19));
        step(1, "adj1_blank");
        check_eq("adj1_dig2_blank", 64'(hex_out[20:14]), 64'(7'h7F));
        check_eq("adj1_dig4_vis", 64'(hex_out[34:28]), 64'(7'h24));
        step(11, "adj1_run");
        adjust = 4'd3;
        step(12, "adj3");

        // Change field while blanked
        adjust = 4'd1;
        step(6, "adj1_again");
        adjust = 4'd2;
        step(1, "adj2_first");
        check_eq("adj2_dig3_vis", 64'(hex_out[27:21]), 64'(7'h30));
        step(9, "adj2_run");

        // Alarm view on hour/minute digits
        adjust = 4'd0; alarm_view = 1'b1;
        alarm_digits = 24'h070000; time_digits = 24'h121559;
        step(1, "alarm");
        check_eq("alarm_dig4", 64'(hex_out[34:28]), 64'(7'h78));
        check_eq("alarm_dig1", 64'(hex_out[13:7]), 64'(7'h12));
        check_eq("alarm_dig0", 64'(hex_out[6:0]), 64'(7'h10));
        step(12, "scan");

        // Leading-zero blanking of the top digit
        alarm_view = 1'b0; time_digits = 24'h091234;
        step(1, "lzb");
`ifdef SMG_LZB_EN
        check_eq("lzb_dig5", 64'(hex_out[41:35]), 64'(7'h7F));
`else
        check_eq("lzb_dig5", 64'(hex_out[41:35]), 64'(7'h40));
`endif

        // Randomised operation
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 11) == 0) adjust = adj_pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0)  time_digits = rand_digits();
            if ($urandom_range(0, 19) == 0) alarm_digits = rand_digits();
            if ($urandom_range(0, 9) == 0)  alarm_view = ~alarm_view;
            step(1, "rand");
        end

        // Asynchronous reset mid-operation
        adjust = 4'd2;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("midrst");
        step(2, "midrst_hold");
        #2 rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if ($urandom_range(0, 11) == 0) adjust = adj_pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0)  time_digits = rand_digits();
            if ($urandom_range(0, 9) == 0)  alarm_view = ~alarm_view;
            step(1, "post_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smg_disp_ctrl.md
Name: smg_disp_ctrl

Overview:
- Parametrised seven-segment display controller for the alarm clock.
- Selects time or alarm digits per digit position, blinks the field under adjustment, and decodes every digit to segments.
- Drives NUM_DIG direct segment outputs plus one time-multiplexed scan output for multiplexed display boards.
- Sits between the clock/alarm counters and the board HEX pins.

Parameters:
- NUM_DIG, 6: digit count; must be even, 2..16; digits pair into fields (field k = digits 2k, 2k+1; digit 0 is least significant).
- BLINK_CNT, 10_000_000: clk cycles per blink half-period.
- SCAN_CNT, 50_000: clk cycles each digit is held on the scan output.
- ALARM_MASK, 6'b111100: width NUM_DIG; bit i=1 means digit i shows alarm_digits when alarm_view=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- adjust  in  4  field under adjustment; 0 = none, k = field k blinks
- time_digits  in  4*NUM_DIG  BCD codes, digit i at bits [4i+3:4i]
- alarm_digits  in  4*NUM_DIG  alarm BCD codes, same packing
- alarm_view  in  1  1 = show alarm digits on masked positions
- hex_out  out  7*NUM_DIG  direct segments, digit i at [7i+6:7i], active-low (bit0 = seg a)
- seg_scan  out  7  segments of the currently scanned digit, active-low
- dig_sel  out  NUM_DIG  one-hot active-high scan enable

Behaviour:
- Reset, asynchronous: all counters are 0 and blink_phase = 0. Every hex_out digit = 7'h7F (blank), seg_scan = 7'h7F, dig_sel = 1, scan index = 0.
- Decode: codes 0-9 map to standard active-low glyphs (0 = 7'h40, 1 = 7'h79, 8 = 7'h00). Codes 10-15 map to 7'h7F (blank). Code 10 is the internal blank code.
- Blink counter:
  - Counts 0..BLINK_CNT-1 and wraps; blink_phase toggles on each wrap.
  - adjust is registered. When adjust differs from its registered value, the counter clears to 0 and blink_phase clears to 0. The new field is therefore visible for a full half-period first.
  - A restart in the same cycle as a wrap: the restart wins, and the phase stays 0.
- Digit select, per digit i, evaluated in priority order:
  1. adjust == field(i) and adjust != 0 and blink_phase == 1 -> code 10.
  2. alarm_view and ALARM_MASK[i] -> alarm_digits code.
  3. Otherwise -> time_digits code.
- adjust values >= NUM_DIG/2 blink nothing. Field 0 can never blink.
- Latency: the selected code is registered and decoding is combinational from that register. hex_out reflects input changes exactly 1 clk later, uniformly for all digits.
- Scan:
  - The scan counter counts 0..SCAN_CNT-1. On wrap, the index advances (NUM_DIG-1 wraps to 0).
  - dig_sel and seg_scan are registered. dig_sel = one-hot(index); seg_scan = decoded segments of the registered digit at index.
  - Each digit is held SCAN_CNT cycles.
- The scan and blink counters are independent and do not reset each other.
- Reset asserted mid-operation returns everything to the reset state immediately. After release, the first update lands on the first rising clk edge.

Optional Feature:
- Macro SMG_LZB_EN: leading-zero blanking.
- When defined: digit NUM_DIG-1 shows blank whenever its selected code is 0 (e.g. 09:30 displays as " 9:30"), in both views, on hex_out and seg_scan.
- When undefined: a 0 in that digit displays the "0" glyph.
- Blink has priority either way. No other digit is affected.

Test Plan (bench params BLINK_CNT=4, SCAN_CNT=2, NUM_DIG=6):
- Reset held, then released with time_digits=24'h123456 -> all outputs 7'h7F during reset. One clk after release, hex_out digit0=glyph 6, digit5=glyph 1; dig_sel=6'b000001.
- adjust 0->1 -> digits 2,3 visible for 4 cycles, blank for 4, visible again. Digits 0,1,4,5 never blank. adjust=3 -> no digit blinks.
- adjust=1 mid-blank, then changed to 2 -> digits 2,3 visible on the next clk; digits 4,5 stay visible for 4 cycles, then blank.
- alarm_view=1, alarm_digits=24'h070000, time_digits=24'h121559 -> digits show 0,7,0,0,5,9 (digits 5..0). Seconds stay from time_digits.
- Scan run for 12 cycles -> dig_sel steps 000001..100000, each held 2 cycles, then wraps. seg_scan matches hex_out of the selected digit each step.
- SMG_LZB_EN defined, time_digits=24'h091234 -> digit5=7'h7F. Undefined -> digit5=7'h40.
